// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer.
//   state_t   : playback FSM states (IDLE, LOAD, PLAY)
//   PERIOD_W  : width of the oscillator compare value
//   DEF_DW    : default duration field width (ticks)
//   DEF_DEPTH : default melody table depth
package note_seq_pkg;

  localparam int PERIOD_W  = 32;
  localparam int DEF_DW    = 16;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Duration-tick prescaler: counts 0..TICK_DIV-1 while enabled and wraps.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   clr  : synchronous clear of the counter (restarts the tick phase)
//   en   : count enable
//   tick : one-cycle pulse on the cycle the counter wraps
module tick_prescaler #(
  parameter int TICK_DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  // Combinational so the wrap cycle itself is the last cycle of a tick;
  // this makes a note of dur ticks last exactly dur*TICK_DIV cycles.
  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer driving the pulse oscillator.
// Plays (period, duration) entries from a small table in order, producing
// the oscillator half-period compare value and an audible gate.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/wr_addr     : table write strobe and index
//   wr_period/wr_dur  : entry contents (period 0 = rest, dur 0 = 1 tick)
//   start/stop        : begin playback at entry 0 / abort (stop wins)
//   loop_en/last_addr : end-of-sequence control, sampled at note end
//   count_max, gate   : oscillator compare value and audible enable
//   busy, cur_addr    : playback active, entry loaded/playing
//   done              : one-cycle pulse on natural end of sequence
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = 4,
  parameter int TICK_DIV = 12000,
  parameter int DW       = DEF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [DW-1:0]       wr_dur,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [AW-1:0]       last_addr,
  output logic [PERIOD_W-1:0] count_max,
  output logic                gate,
  output logic                busy,
  output logic [AW-1:0]       cur_addr,
  output logic                done
);

  localparam logic [DW-1:0] DUR_ONE = DW'(1);

  // Melody table (not reset)
  logic [PERIOD_W-1:0] period_mem [DEPTH];
  logic [DW-1:0]       dur_mem    [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      period_mem[wr_addr] <= wr_period;
      dur_mem[wr_addr]    <= wr_dur;
    end
  end

  logic [PERIOD_W-1:0] ld_period;
  logic [DW-1:0]       ld_dur;

  assign ld_period = period_mem[cur_addr];
  assign ld_dur    = dur_mem[cur_addr];

  // FSM and datapath registers
  state_t              state_reg,     state_next;
  logic [AW-1:0]       cur_addr_reg,  cur_addr_next;
  logic [PERIOD_W-1:0] count_max_reg, count_max_next;
  logic                gate_reg,      gate_next;
  logic                done_reg,      done_next;
  logic [DW-1:0]       dur_cnt_reg,   dur_cnt_next;
  logic                tick;

  // Tick phase restarts every time a note is loaded.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_reg != PLAY),
    .en   (state_reg == PLAY),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      count_max_reg <= '0;
      gate_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dur_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      count_max_reg <= count_max_next;
      gate_reg      <= gate_next;
      done_reg      <= done_next;
      dur_cnt_reg   <= dur_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    count_max_next = count_max_reg;
    gate_next      = gate_reg;
    done_next      = 1'b0;
    dur_cnt_next   = dur_cnt_reg;

    if (stop) begin
      state_next = IDLE;
      gate_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          gate_next = 1'b0;
          if (start) begin
            state_next    = LOAD;
            cur_addr_next = '0;
          end
        end

        // The entry is captured here; later writes to the same slot only
        // affect the next time it is loaded.
        LOAD: begin
          count_max_next = ld_period;
          gate_next      = (ld_period != '0);
          dur_cnt_next   = (ld_dur == '0) ? DUR_ONE : ld_dur;
          state_next     = PLAY;
        end

        PLAY: begin
          if (tick) begin
            if (dur_cnt_reg == DUR_ONE) begin
              if (cur_addr_reg != last_addr) begin
                cur_addr_next = cur_addr_reg + 1'b1;  // wraps mod DEPTH
                state_next    = LOAD;
              end else if (loop_en) begin
                cur_addr_next = '0;
                state_next    = LOAD;
              end else begin
                state_next = IDLE;
                gate_next  = 1'b0;
                done_next  = 1'b1;
              end
            end else begin
              dur_cnt_next = dur_cnt_reg - 1'b1;
            end
          end
        end

        default: begin
          state_next = IDLE;
          gate_next  = 1'b0;
        end
      endcase
    end
  end

  assign count_max = count_max_reg;
  assign gate      = gate_reg;
  assign busy      = (state_reg != IDLE);
  assign cur_addr  = cur_addr_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  localparam int TICK = 4;
  localparam int NONE = 1 << 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_period;
  logic [15:0] wr_dur;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [3:0]  last_addr;
  logic [31:0] count_max;
  logic        gate;
  logic        busy;
  logic [3:0]  cur_addr;
  logic        done;

  note_sequencer #(
    .DEPTH    (16),
    .AW       (4),
    .TICK_DIV (TICK),
    .DW       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_period (wr_period),
    .wr_dur    (wr_dur),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .last_addr (last_addr),
    .count_max (count_max),
    .gate      (gate),
    .busy      (busy),
    .cur_addr  (cur_addr),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cm;
    logic        g;
    logic        b;
    logic [3:0]  a;
    logic        d;
  } exp_t;

  exp_t exp_q[$];
  exp_t gen_q[$];

  int tests  = 0;
  int failed = 0;

  // Reference table copy and last observable output state
  logic [31:0] tb_per [16];
  int          tb_dur [16];
  logic [31:0] exp_cm   = 32'd0;
  int          exp_addr = 0;

  // Monitor: one expected record per cycle while the scoreboard is non-empty
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (count_max !== e.cm || gate !== e.g || busy !== e.b ||
          cur_addr !== e.a || done !== e.d) begin
        failed++;
        $display("FAIL cycle_check t=%0t: got cm=%0d gate=%b busy=%b addr=%0d done=%b, need cm=%0d gate=%b busy=%b addr=%0d done=%b",
                 $time, count_max, gate, busy, cur_addr, done, e.cm, e.g, e.b, e.a, e.d);
      end
    end
  end

  task automatic push_e(input logic [31:0] cm, input logic g, input logic b,
                        input int a, input logic d);
    exp_t e;
    e.cm = cm; e.g = g; e.b = b; e.a = a[3:0]; e.d = d;
    gen_q.push_back(e);
  endtask

  // Behavioural model: walks notes (LOAD cycle then dur*TICK play cycles)
  // and emits the expected outputs for every cycle after start is taken.
  task automatic gen_trace(input int stop_c, input int wr_c, input int wa,
                           input logic [31:0] wp, input int wd,
                           input int last0, input int loop0, input int chg_c,
                           input int last1, input int loop1);
    int k, addr, dur, lst, lp;
    logic [31:0] per, cm;
    logic g;
    gen_q.delete();
    if (stop_c == -1) begin
      push_e(exp_cm, 1'b0, 1'b0, exp_addr, 1'b0);
      push_e(exp_cm, 1'b0, 1'b0, exp_addr, 1'b0);
      return;
    end
    cm = exp_cm; g = 1'b0; k = 0; addr = 0;
    forever begin
      if (k == stop_c + 1) begin
        push_e(cm, 1'b0, 1'b0, addr, 1'b0);
        push_e(cm, 1'b0, 1'b0, addr, 1'b0);
        exp_cm = cm; exp_addr = addr;
        return;
      end
      push_e(cm, g, 1'b1, addr, 1'b0);
      if (wr_c >= 0 && wr_c < k && wa == addr) begin
        per = wp; dur = wd;
      end else begin
        per = tb_per[addr]; dur = tb_dur[addr];
      end
      if (dur == 0) dur = 1;
      k++;
      for (int i = 0; i < dur * TICK; i++) begin
        if (k == stop_c + 1) begin
          push_e(cm, 1'b0, 1'b0, addr, 1'b0);
          push_e(cm, 1'b0, 1'b0, addr, 1'b0);
          exp_cm = cm; exp_addr = addr;
          return;
        end
        cm = per; g = (per != 0);
        push_e(cm, g, 1'b1, addr, 1'b0);
        k++;
      end
      lst = (chg_c >= 0 && chg_c <= k - 1) ? last1 : last0;
      lp  = (chg_c >= 0 && chg_c <= k - 1) ? loop1 : loop0;
      if (addr != lst) begin
        addr = (addr + 1) % 16;
      end else if (lp != 0) begin
        addr = 0;
      end else begin
        push_e(cm, 1'b0, 1'b0, addr, 1'b1);
        push_e(cm, 1'b0, 1'b0, addr, 1'b0);
        exp_cm = cm; exp_addr = addr;
        return;
      end
      if (k > 3000) return;
    end
  endtask

  task automatic write_entry(input int a, input logic [31:0] p, input int d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a[3:0]; wr_period = p; wr_dur = d[15:0];
    @(posedge clk); #1;
    wr_en = 1'b0;
    tb_per[a] = p; tb_dur[a] = d;
  endtask

  task automatic run(input string name, input int stop_c, input int wr_c,
                     input int wa, input logic [31:0] wp, input int wd,
                     input int last0, input int loop0, input int chg_c,
                     input int last1, input int loop1, input int sb_c);
    int len, t;
    @(posedge clk); #1;
    last_addr = last0[3:0]; loop_en = loop0[0];
    start = 1'b1; stop = (stop_c == -1);
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    gen_trace(stop_c, wr_c, wa, wp, wd, last0, loop0, chg_c, last1, loop1);
    len = gen_q.size();
    foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
    for (int k = 0; k < len; k++) begin
      stop  = (k == stop_c);
      start = (k == sb_c);
      wr_en = (k == wr_c);
      if (k == wr_c) begin
        wr_addr = wa[3:0]; wr_period = wp; wr_dur = wd[15:0];
      end
      if (chg_c >= 0 && k >= chg_c) begin
        last_addr = last1[3:0]; loop_en = loop1[0];
      end
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 8) begin
      @(negedge clk); #1;
      t++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain_%s: %0d records left, need 0", name, exp_q.size());
      exp_q.delete();
    end
    if (wr_c >= 0 && wr_c < len) begin
      tb_per[wa] = wp; tb_dur[wa] = wd;
    end
    $display("[TB] run %s: %0d cycles checked, end cm=%0d addr=%0d", name, len, exp_cm, exp_addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p, wp;
    int l0, lp0, l1, lp1, chg, st, wc, wa, wd;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push_e(32'd0, 1'b0, 1'b0, 0, 1'b0);
    push_e(32'd0, 1'b0, 1'b0, 0, 1'b0);
    foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
    gen_q.delete();
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] run reset: outputs idle");

    // Empty table: start then stop while in LOAD, count_max must stay 0
    run("nowrite_stop", 0, -1, 0, 32'd0, 0, 0, 0, -1, 0, 0, NONE);

    write_entry(0, 32'd100, 2);
    write_entry(1, 32'd0,   1);
    write_entry(2, 32'd50,  3);
    run("melody", NONE, -1, 0, 32'd0, 0, 2, 0, -1, 0, 0, NONE);

    // Loop back to entry 0, start pulse while busy, stop mid-note
    run("loop_stop", 30, -1, 0, 32'd0, 0, 2, 1, -1, 0, 0, 5);

    write_entry(0, 32'd33, 0);
    run("dur_zero", NONE, -1, 0, 32'd0, 0, 0, 0, -1, 0, 0, NONE);

    // Rewrite entry 1 while it plays; new value heard on next iteration
    write_entry(0, 32'd10,  1);
    write_entry(1, 32'd200, 2);
    run("mid_write", 25, 8, 1, 32'd77, 1, 1, 1, -1, 0, 0, NONE);

    // start and stop together from IDLE
    run("start_stop", -1, -1, 0, 32'd0, 0, 1, 0, -1, 0, 0, NONE);

    // last_addr lowered below cur_addr: plays through 15, wraps, ends at 2
    for (int i = 0; i < 16; i++) write_entry(i, 32'(i * 10 + 1), 0);
    run("wrap_end", NONE, -1, 0, 32'd0, 0, 5, 0, 22, 2, 0, NONE);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) p = 32'd0;
        else p = $urandom();
        write_entry(i, p, $urandom_range(0, 2));
      end
      l0 = $urandom_range(0, 15); lp0 = $urandom_range(0, 1);
      chg = -1; l1 = l0; lp1 = lp0;
      if ($urandom_range(0, 1) == 1) begin
        chg = $urandom_range(0, 40); l1 = $urandom_range(0, 15); lp1 = $urandom_range(0, 1);
      end
      st = NONE;
      if (lp0 != 0 || lp1 != 0 || $urandom_range(0, 3) == 0) st = $urandom_range(3, 150);
      wc = -1; wa = 0; wp = 32'd0; wd = 0;
      if ($urandom_range(0, 1) == 1) begin
        wc = $urandom_range(0, 60); wa = $urandom_range(0, 15);
        wp = $urandom(); wd = $urandom_range(0, 2);
      end
      run("random", st, wc, wa, wp, wd, l0, lp0, chg, l1, lp1, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
